data_memory_arbiter: RTL and testbench

- Two-requester arbiter and access sequencer in front of the vector data memory (ports we, vf, addr, wd, rd).
- Port 0 is the core load/store stage; port 1 is the image loader/host DMA used to preload and drain alpha-composition frames.
- Grants one request at a time with round-robin fairness.
- Drives the memory from registered signals and returns read data or a write acknowledge with a fixed latency.

---
 rtl/data_memory_arbiter.sv | 162 ++++++++++++++++
 tb/tb_data_memory_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: two-port round-robin arbiter and access sequencer
// in front of the vector data memory.
// Each granted request runs IDLE -> ACCESS -> RESP, so at most one access
// completes every three cycles.
// Optional macro DATA_MEMORY_ARBITER_PERF_EN adds saturating 16-bit
// grant and conflict counters.
`timescale 1ns/1ps
module data_memory_arbiter #(
  parameter int unsigned ADDR_W = 128,
  parameter int unsigned DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic              req0_vf,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wd,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic              req1_vf,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wd,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_rd,
  output logic              mem_we,
  output logic              mem_vf,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
`ifdef DATA_MEMORY_ARBITER_PERF_EN
  ,
  output logic [15:0]       perf_grant0,
  output logic [15:0]       perf_grant1,
  output logic [15:0]       perf_conflict
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_owner;
  logic                r_last_grant;
  logic                r_mem_we;
  logic                r_mem_vf;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wd;
  logic                r_rsp_valid;
  logic                r_rsp_id;
  logic [DATA_W-1:0]   r_rsp_rd;

  logic                w_both;
  logic                w_accept;
  logic                w_winner;
  logic                w_sel_we;
  logic                w_sel_vf;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wd;

  // Winner selection: on a tie the port that did not win last time goes first
  always_comb begin
    w_both     = req0_valid & req1_valid;
    w_accept   = (r_state == S_IDLE) & (req0_valid | req1_valid);
    w_winner   = w_both ? ~r_last_grant : req1_valid;
    w_sel_we   = w_winner ? req1_we   : req0_we;
    w_sel_vf   = w_winner ? req1_vf   : req0_vf;
    w_sel_addr = w_winner ? req1_addr : req0_addr;
    w_sel_wd   = w_winner ? req1_wd   : req0_wd;
  end

  assign req0_ready = w_accept & ~w_winner;
  assign req1_ready = w_accept &  w_winner;

  assign mem_we    = r_mem_we;
  assign mem_vf    = r_mem_vf;
  assign mem_addr  = r_mem_addr;
  assign mem_wd    = r_mem_wd;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_rd    = r_rsp_rd;

  // Access sequencer: latch the winner, drive one memory cycle, then respond
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_mem_we     <= 1'b0;
      r_mem_vf     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wd     <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_rd     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rsp_valid <= 1'b0;
          if (w_accept) begin
            r_mem_we     <= w_sel_we;
            r_mem_vf     <= w_sel_vf;
            r_mem_addr   <= w_sel_addr;
            r_mem_wd     <= w_sel_wd;
            r_owner      <= w_winner;
            r_last_grant <= w_winner;
            r_state      <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          r_mem_we    <= 1'b0;
          r_rsp_rd    <= r_mem_we ? '0 : mem_rd;
          r_rsp_valid <= 1'b1;
          r_rsp_id    <= r_owner;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: begin
          r_mem_we    <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

`ifdef DATA_MEMORY_ARBITER_PERF_EN
  logic [15:0] r_perf_grant0;
  logic [15:0] r_perf_grant1;
  logic [15:0] r_perf_conflict;

  assign perf_grant0   = r_perf_grant0;
  assign perf_grant1   = r_perf_grant1;
  assign perf_conflict = r_perf_conflict;

  // Saturating event counters for grants per port and contended IDLE cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_grant0   <= 16'd0;
      r_perf_grant1   <= 16'd0;
      r_perf_conflict <= 16'd0;
    end else begin
      if (req0_ready && (r_perf_grant0 != 16'hFFFF))
        r_perf_grant0 <= r_perf_grant0 + 16'd1;
      if (req1_ready && (r_perf_grant1 != 16'hFFFF))
        r_perf_grant1 <= r_perf_grant1 + 16'd1;
      if ((r_state == S_IDLE) && w_both && (r_perf_conflict != 16'hFFFF))
        r_perf_conflict <= r_perf_conflict + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Self-checking bench for data_memory_arbiter with a behavioural lane memory.
`timescale 1ns/1ps
module tb_data_memory_arbiter;

  localparam int unsigned AW = 128;
  localparam int unsigned DW = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 1'b0, req0_we = 1'b0, req0_vf = 1'b0;
  logic [AW-1:0] req0_addr = '0;
  logic [DW-1:0] req0_wd = '0;
  logic          req1_valid = 1'b0, req1_we = 1'b0, req1_vf = 1'b0;
  logic [AW-1:0] req1_addr = '0;
  logic [DW-1:0] req1_wd = '0;
  logic          req0_ready, req1_ready;
  logic          rsp_valid, rsp_id;
  logic [DW-1:0] rsp_rd;
  logic          mem_we, mem_vf;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;
`ifdef DATA_MEMORY_ARBITER_PERF_EN
  logic [15:0]   perf_grant0, perf_grant1, perf_conflict;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  data_memory_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_vf(req0_vf), .req0_addr(req0_addr), .req0_wd(req0_wd),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_vf(req1_vf), .req1_addr(req1_addr), .req1_wd(req1_wd),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rd(rsp_rd),
    .mem_we(mem_we), .mem_vf(mem_vf), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .mem_rd(mem_rd)
`ifdef DATA_MEMORY_ARBITER_PERF_EN
    ,
    .perf_grant0(perf_grant0), .perf_grant1(perf_grant1),
    .perf_conflict(perf_conflict)
`endif
  );

  // Behavioural memory: one 32-bit word per address, vector = 4 consecutive words
  logic [31:0] mem [16384];
  logic [13:0] w_idx;

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'd0;
  end

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[13:0]] <= mem_wd[31:0];
      if (mem_vf) begin
        mem[14'(mem_addr[13:0] + 14'd1)] <= mem_wd[63:32];
        mem[14'(mem_addr[13:0] + 14'd2)] <= mem_wd[95:64];
        mem[14'(mem_addr[13:0] + 14'd3)] <= mem_wd[127:96];
      end
    end
  end

  always_comb begin
    w_idx         = mem_addr[13:0];
    mem_rd        = '0;
    mem_rd[31:0]  = mem[w_idx];
    if (mem_vf) begin
      mem_rd[63:32]  = mem[14'(w_idx + 14'd1)];
      mem_rd[95:64]  = mem[14'(w_idx + 14'd2)];
      mem_rd[127:96] = mem[14'(w_idx + 14'd3)];
    end
  end

  typedef struct {
    logic          port;
    logic          we;
    logic          vf;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic [DW-1:0] exp_rd;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic port, input logic valid, input logic we, input logic vf,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    if (port) begin
      req1_valid = valid; req1_we = we; req1_vf = vf; req1_addr = addr; req1_wd = wd;
    end else begin
      req0_valid = valid; req0_we = we; req0_vf = vf; req0_addr = addr; req0_wd = wd;
    end
  endtask

  // Single-port transaction; call at posedge+2 with the FSM in IDLE
  task automatic txn(input vec_t v);
    int n;
    logic rdy;
    drive(v.port, 1'b1, v.we, v.vf, v.addr, v.wd);
    #1;
    n = 0;
    rdy = v.port ? req1_ready : req0_ready;
    while (!rdy && n < 20) begin
      @(posedge clk); #2; n++;
      rdy = v.port ? req1_ready : req0_ready;
    end
    if (!rdy) begin
      chk("ready_timeout", 1'b0, 1'b1);
      drive(v.port, 1'b0, 1'b0, 1'b0, '0, '0);
      return;
    end
    chk("other_ready_low", v.port ? req0_ready : req1_ready, 1'b0);
    @(posedge clk); #1;
    drive(v.port, 1'b0, v.we, v.vf, v.addr, v.wd);
    #1;
    chk("access_mem_we", mem_we, v.we);
    chk("access_mem_vf", mem_vf, v.vf);
    chk("access_mem_addr", mem_addr, v.addr);
    if (v.we) chk("access_mem_wd", mem_wd, v.wd);
    chk("access_no_rsp", rsp_valid, 1'b0);
    @(posedge clk); #2;
    chk("rsp_valid", rsp_valid, 1'b1);
    chk("rsp_id", rsp_id, v.port);
    chk("rsp_rd", rsp_rd, v.exp_rd);
    chk("resp_mem_we", mem_we, 1'b0);
    @(posedge clk); #2;
    chk("rsp_pulse_end", rsp_valid, 1'b0);
  endtask

  // Both ports held valid: grants must alternate starting from first_port
  task automatic contention(input int count, input logic first_port);
    int n;
    logic g;
    drive(1'b0, 1'b1, 1'b0, 1'b1, 128'd0, '0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 128'd4, '0);
    #1;
    for (int k = 0; k < count; k++) begin
      n = 0;
      while (!(req0_ready | req1_ready) && n < 20) begin
        @(posedge clk); #2; n++;
      end
      chk("cont_one_ready", 128'(req0_ready) + 128'(req1_ready), 128'd1);
      g = req1_ready;
      chk("cont_grant_order", g, first_port ^ 1'(k & 1));
      @(posedge clk); #2;
      chk("cont_mem_addr", mem_addr, g ? 128'd4 : 128'd0);
      chk("cont_no_ready_access", 128'(req0_ready) + 128'(req1_ready), 128'd0);
      @(posedge clk); #2;
      chk("cont_rsp_valid", rsp_valid, 1'b1);
      chk("cont_rsp_id", rsp_id, g);
      chk("cont_no_ready_resp", 128'(req0_ready) + 128'(req1_ready), 128'd0);
      @(posedge clk); #1;
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #2;
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{1'b0, 1'b1, 1'b1, 128'd0, {32'd4, 32'd3, 32'd2, 32'd1}, 128'd0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 128'd0, 128'd0, {32'd4, 32'd3, 32'd2, 32'd1}};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 128'd10000, 128'd1, 128'd0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 128'd10000, 128'd0, 128'd1};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 128'd8, 128'h1111, 128'd0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 128'd8, 128'd0, 128'h1111};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 128'd100,
                {32'hDDDD, 32'hCCCC, 32'hBBBB, 32'hAAAA}, 128'd0};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 128'd100, 128'd0, 128'hAAAA};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 128'd10001,
                {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5}, 128'd0};
    vecs[9] = '{1'b1, 1'b0, 1'b1, 128'd10000, 128'd0, {32'd0, 32'd0, 32'd5, 32'd1}};

    // Reset state
    @(posedge clk); @(posedge clk); #2;
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_id", rsp_id, 1'b0);
    chk("rst_rsp_rd", rsp_rd, 128'd0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_vf", mem_vf, 1'b0);
    chk("rst_mem_addr", mem_addr, 128'd0);
    chk("rst_mem_wd", mem_wd, 128'd0);
    chk("rst_no_ready", 128'(req0_ready) + 128'(req1_ready), 128'd0);
    rst = 1'b0;
    @(posedge clk); #2;
    chk("idle_no_ready", 128'(req0_ready) + 128'(req1_ready), 128'd0);

    // Table-driven single-port transactions
    for (int i = 0; i < 10; i++) txn(vecs[i]);

    // Contention from reset: 0,1,0,1
    do_reset();
    contention(4, 1'b0);

    // Hold-off: port 1 raises valid during port 0's ACCESS
    drive(1'b0, 1'b1, 1'b1, 1'b0, 128'd200, 128'd7);
    #1;
    chk("hold_p0_ready", req0_ready, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 128'd0, 128'h55);
    #1;
    chk("hold_ready_access", req1_ready, 1'b0);
    @(posedge clk); #2;
    chk("hold_ready_resp", req1_ready, 1'b0);
    chk("hold_p0_rsp_id", rsp_id, 1'b0);
    @(posedge clk); #2;
    chk("hold_ready_idle", req1_ready, 1'b1);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    chk("hold_latched_addr", mem_addr, 128'd0);
    chk("hold_latched_vf", mem_vf, 1'b1);
    chk("hold_latched_wd", mem_wd, 128'h55);
    chk("hold_latched_we", mem_we, 1'b0);
    @(posedge clk); #2;
    chk("hold_rsp_id", rsp_id, 1'b1);
    chk("hold_rsp_rd", rsp_rd, {32'd4, 32'd3, 32'd2, 32'd1});
    @(posedge clk); #2;

    // Reset during ACCESS of a write
    drive(1'b0, 1'b1, 1'b1, 1'b0, 128'd8, 128'hDEAD);
    #1;
    chk("midw_ready", req0_ready, 1'b1);
    @(posedge clk); #1;
    chk("midw_mem_we_set", mem_we, 1'b1);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    chk("midw_mem_we_drop", mem_we, 1'b0);
    @(posedge clk); #2;
    chk("midw_no_rsp1", rsp_valid, 1'b0);
    @(posedge clk); #2;
    chk("midw_no_rsp2", rsp_valid, 1'b0);
    rst = 1'b0;
    @(posedge clk); #2;
    chk("midw_no_rsp3", rsp_valid, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 128'd0, '0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 128'd4, '0);
    #1;
    chk("midw_tie_p0", req0_ready, 1'b1);
    chk("midw_tie_p1", req1_ready, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    v = vecs[5];
    txn(v);

`ifdef DATA_MEMORY_ARBITER_PERF_EN
    do_reset();
    chk("perf_rst_g0", 128'(perf_grant0), 128'd0);
    contention(2, 1'b0);
    txn(vecs[1]);
    txn(vecs[7]);
    txn(vecs[3]);
    chk("perf_grant0", 128'(perf_grant0), 128'd3);
    chk("perf_grant1", 128'(perf_grant1), 128'd2);
    chk("perf_conflict", 128'(perf_conflict), 128'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
